timer_nbit_v2: RTL and testbench
================================

// Module: timer_nbit_v2
// PURPOSE
//  N-bit general-purpose timer, successor of the v1 timer. Adds a programmable prescaler,
//  a period register, up/down counting, auto-reload vs one-shot modes and NUM_CH
//  independent match channels. Sits in the peripheral SFR block. Control pulses arrive
//  from SFR decode. Event pulses go to the interrupt controller.
// PARAMETERS
//  N        32  counter width (1..32)
//  NUM_CH   4   number of match channels (1..8)
//  PSC_W    8   prescaler width; divide ratio = tmr_psc+1
// PORTS
//  sys_clk        in   1         single system clock; all flops on posedge
//  sys_rst        in   1         asynchronous, active-high reset
//  sys_clk_en     in   1         chip low-power gate; 0 freezes prescaler and counter
//  tmr_on         in   1         module enable; 0 freezes prescaler and counter (state kept)
//  tmr_start      in   1         1-cycle pulse: set running
//  tmr_stop       in   1         1-cycle pulse: clear running (wins over start)
//  tmr_rst        in   1         1-cycle pulse: counter and prescaler to 0
//  tmr_ld         in   1         1-cycle pulse: counter <= tmr_ld_val, prescaler to 0
//  tmr_ld_val     in   N         load value
//  tmr_period     in   N         terminal count (up) / reload value (down)
//  tmr_dir        in   1         0 = count up, 1 = count down
//  tmr_one_shot   in   1         1 = stop at terminal event, 0 = auto-reload
//  tmr_psc        in   PSC_W     prescaler compare value
//  ch_match_val   in   NUM_CH*N  channel i compare value at [i*N +: N]
//  ch_match_en    in   NUM_CH    per-channel event enable
//  ovf_en         in   1         overflow/underflow event enable
//  tmr_value      out  N         current counter value (registered)
//  tmr_running    out  1         running state
//  match_event    out  NUM_CH    1-cycle registered match pulses
//  ovf_event      out  1         1-cycle registered terminal-count pulse
// BEHAVIOUR
//  - Reset: tmr_value=0, running=0, prescaler=0, all events=0 (and pwm_out=0).
//  - active = sys_clk_en & tmr_on. tick = active & running & (psc_cnt == tmr_psc).
//  - Prescaler: psc_cnt increments while active & running. It clears on tick, start,
//    tmr_rst and tmr_ld. With tmr_psc=0, a tick occurs every active cycle.
//  - Running: start&!stop -> 1 next cycle. stop (alone or with start) -> 0 next cycle.
//    One-shot terminal event -> 0.
//  - Counter priority per cycle: tmr_rst > tmr_ld > tick > hold.
//    rst/ld apply even when not running or not active.
//  - Up: value==tmr_period on tick -> value 0, ovf. Otherwise value+1.
//  - Down: value==0 on tick -> value tmr_period, ovf. Otherwise value-1.
//  - Value > period in up mode counts to 2^N-1 then wraps to 0 with ovf (N-bit natural wrap).
//  - tmr_period=0: up mode stays at 0 and raises ovf every tick.
//  - One-shot: on terminal event the value takes the wrap value, ovf fires and running clears
//    in the same edge.
//  - Latency: start at cycle t -> running=1 at t+1. With psc=0 the first value change is at t+2.
//  - match_event[i]: asserted in the same cycle tmr_value first shows ch_match_val[i],
//    only if reached by a tick and ch_match_en[i]=1. Never asserted on rst/ld.
//    Multiple channels may fire together.
//  - ovf_event: same timing as the wrapped value, gated by ovf_en.
//  - Events are never persistent; SFR flags latch them externally.
//  - tmr_rst or tmr_ld in the same cycle as a tick: the tick is discarded, no events.
//  - Reset mid-count: immediate asynchronous return to reset values.
// CONFIGURATION
//  TMR_PWM_OUT_EN defined: extra output pwm_out[NUM_CH] (registered).
//    pwm_out[i] = running & (next_value < ch_match_val[i]) in up mode,
//    > in down mode. Held at 0 when not running.
//  TMR_PWM_OUT_EN undefined: port and logic absent; all else identical.
// TESTING
//  psc=0, period=4, up, auto-reload, start -> value 0,1,2,3,4,0. ovf pulse with 0. Stays running.
//  psc=2, period=2, up -> value changes every 3 cycles. ovf once per 9 cycles.
//  down, one_shot, ld_val=3 -> values 2,1,0,period (3→2 at the first tick); ovf once; running=0.
//  ch0 match=2, ch1 match=2, both enabled, period=5 up -> match_event=2'b11 one cycle at value 2.
//  tmr_rst coincident with a tick at value==match -> value 0, no match/ovf event.
//  stop and start same cycle -> running=0. sys_rst mid-count -> all outputs 0 immediately.

Source files
------------

// File: rtl/timer_nbit_v2.sv
// N-bit timer with prescaler, period reload, up/down counting, one-shot mode and
// NUM_CH match channels. Define TMR_PWM_OUT_EN to add the registered pwm_out port.
module timer_nbit_v2 #(
  parameter int N      = 32,
  parameter int NUM_CH = 4,
  parameter int PSC_W  = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                sys_clk_en,
  input  logic                tmr_on,
  input  logic                tmr_start,
  input  logic                tmr_stop,
  input  logic                tmr_rst,
  input  logic                tmr_ld,
  input  logic [N-1:0]        tmr_ld_val,
  input  logic [N-1:0]        tmr_period,
  input  logic                tmr_dir,
  input  logic                tmr_one_shot,
  input  logic [PSC_W-1:0]    tmr_psc,
  input  logic [NUM_CH*N-1:0] ch_match_val,
  input  logic [NUM_CH-1:0]   ch_match_en,
  input  logic                ovf_en,
  output logic [N-1:0]        tmr_value,
  output logic                tmr_running,
  output logic [NUM_CH-1:0]   match_event,
`ifdef TMR_PWM_OUT_EN
  output logic [NUM_CH-1:0]   pwm_out,
`endif
  output logic                ovf_event
);

  logic [N-1:0]      r_value;
  logic              r_running;
  logic [PSC_W-1:0]  r_psc;
  logic [NUM_CH-1:0] r_match;
  logic              r_ovf;

  logic              w_active;
  logic              w_tick;
  logic              w_tick_ok;
  logic [N:0]        w_step;
  logic              w_term;
  logic [N-1:0]      w_val_nxt;
  logic              w_run_nxt;
  logic [PSC_W-1:0]  w_psc_nxt;
  logic [NUM_CH-1:0] w_match_nxt;
  logic              w_ovf_nxt;

  // Returns {terminal, next value} for one tick; up mode also wraps at all-ones.
  function automatic logic [N:0] f_step(input logic [N-1:0] val,
                                        input logic [N-1:0] per,
                                        input logic         dn);
    logic [N:0] res;
    if (!dn) begin
      if (val == per || val == {N{1'b1}}) res = {1'b1, {N{1'b0}}};
      else                                res = {1'b0, val + N'(1)};
    end else begin
      if (val == '0) res = {1'b1, per};
      else           res = {1'b0, val - N'(1)};
    end
    return res;
  endfunction

  assign w_active  = sys_clk_en & tmr_on;
  assign w_tick    = w_active & r_running & (r_psc == tmr_psc);
  // A tick coinciding with rst/ld is discarded entirely, including its events.
  assign w_tick_ok = w_tick & ~tmr_rst & ~tmr_ld;
  assign w_step    = f_step(r_value, tmr_period, tmr_dir);
  assign w_term    = w_step[N];

  always_comb begin
    w_val_nxt   = r_value;
    w_psc_nxt   = r_psc;
    w_run_nxt   = r_running;
    w_match_nxt = '0;
    w_ovf_nxt   = 1'b0;

    if (tmr_rst)        w_val_nxt = '0;
    else if (tmr_ld)    w_val_nxt = tmr_ld_val;
    else if (w_tick)    w_val_nxt = w_step[N-1:0];

    if (tmr_start | tmr_rst | tmr_ld | w_tick) w_psc_nxt = '0;
    else if (w_active & r_running)             w_psc_nxt = r_psc + PSC_W'(1);

    if (tmr_stop)                                   w_run_nxt = 1'b0;
    else if (tmr_start)                             w_run_nxt = 1'b1;
    else if (w_tick_ok & w_term & tmr_one_shot)     w_run_nxt = 1'b0;

    w_ovf_nxt = w_tick_ok & w_term & ovf_en;
    for (int i = 0; i < NUM_CH; i++) begin
      w_match_nxt[i] = w_tick_ok & ch_match_en[i] &
                       (w_step[N-1:0] == ch_match_val[i*N +: N]);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_value   <= '0;
      r_running <= 1'b0;
      r_psc     <= '0;
      r_match   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_value   <= w_val_nxt;
      r_running <= w_run_nxt;
      r_psc     <= w_psc_nxt;
      r_match   <= w_match_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

`ifdef TMR_PWM_OUT_EN
  logic [NUM_CH-1:0] r_pwm;
  logic [NUM_CH-1:0] w_pwm_nxt;

  // PWM tracks the value being registered this edge so it lines up with tmr_value.
  always_comb begin
    w_pwm_nxt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (tmr_dir) w_pwm_nxt[i] = w_run_nxt & (w_val_nxt > ch_match_val[i*N +: N]);
      else         w_pwm_nxt[i] = w_run_nxt & (w_val_nxt < ch_match_val[i*N +: N]);
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_pwm <= '0;
    else         r_pwm <= w_pwm_nxt;
  end

  assign pwm_out = r_pwm;
`endif

  assign tmr_value   = r_value;
  assign tmr_running = r_running;
  assign match_event = r_match;
  assign ovf_event   = r_ovf;

endmodule

// File: tb/tb_timer_nbit_v2.sv
// Randomised and directed bench for timer_nbit_v2 against a behavioural model
// that tracks counter, running flag and prescaler as plain integers.
module tb_timer_nbit_v2;
  localparam int N      = 8;
  localparam int NUM_CH = 2;
  localparam int PSC_W  = 4;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic                sys_clk_en, tmr_on, tmr_start, tmr_stop, tmr_rst, tmr_ld;
  logic [N-1:0]        tmr_ld_val, tmr_period;
  logic                tmr_dir, tmr_one_shot;
  logic [PSC_W-1:0]    tmr_psc;
  logic [NUM_CH*N-1:0] ch_match_val;
  logic [NUM_CH-1:0]   ch_match_en;
  logic                ovf_en;
  logic [N-1:0]        tmr_value;
  logic                tmr_running;
  logic [NUM_CH-1:0]   match_event;
  logic                ovf_event;

  timer_nbit_v2 #(.N(N), .NUM_CH(NUM_CH), .PSC_W(PSC_W)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sys_clk_en(sys_clk_en), .tmr_on(tmr_on),
    .tmr_start(tmr_start), .tmr_stop(tmr_stop), .tmr_rst(tmr_rst), .tmr_ld(tmr_ld),
    .tmr_ld_val(tmr_ld_val), .tmr_period(tmr_period), .tmr_dir(tmr_dir),
    .tmr_one_shot(tmr_one_shot), .tmr_psc(tmr_psc), .ch_match_val(ch_match_val),
    .ch_match_en(ch_match_en), .ovf_en(ovf_en), .tmr_value(tmr_value),
    .tmr_running(tmr_running), .match_event(match_event), .ovf_event(ovf_event)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int                m_val, m_run, m_psc;
  logic [NUM_CH-1:0] m_match;
  bit                m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_val = 0; m_run = 0; m_psc = 0; m_match = '0; m_ovf = 0;
  endtask

  // Applies the timer rules for one clock edge given the current input values.
  task automatic model_edge();
    int  lim, nv, npsc;
    bit  active, tick, term, os_stop;
    lim = 1 << N;
    active = sys_clk_en && tmr_on;
    tick = active && (m_run != 0) && (m_psc == int'(tmr_psc));
    if (tmr_start || tmr_rst || tmr_ld || tick) npsc = 0;
    else if (active && m_run != 0)              npsc = (m_psc + 1) % (1 << PSC_W);
    else                                        npsc = m_psc;
    term = 0;
    if (!tmr_dir) begin
      if (m_val == int'(tmr_period) || m_val == lim - 1) begin nv = 0; term = 1; end
      else nv = m_val + 1;
    end else begin
      if (m_val == 0) begin nv = int'(tmr_period); term = 1; end
      else nv = m_val - 1;
    end
    m_match = '0; m_ovf = 0; os_stop = 0;
    if (tmr_rst)     m_val = 0;
    else if (tmr_ld) m_val = int'(tmr_ld_val);
    else if (tick) begin
      m_val = nv;
      m_ovf = term && ovf_en;
      os_stop = term && tmr_one_shot;
      for (int i = 0; i < NUM_CH; i++)
        if (ch_match_en[i] && nv == int'(ch_match_val[i*N +: N])) m_match[i] = 1'b1;
    end
    if (tmr_stop)       m_run = 0;
    else if (tmr_start) m_run = 1;
    else if (os_stop)   m_run = 0;
    m_psc = npsc;
  endtask

  task automatic cyc();
    model_edge();
    @(posedge sys_clk);
    #1;
    check("value",   32'(tmr_value),   32'(m_val));
    check("running", 32'(tmr_running), 32'(m_run));
    check("match",   32'(match_event), 32'(m_match));
    check("ovf",     32'(ovf_event),   32'(m_ovf));
    tmr_start = 0; tmr_stop = 0; tmr_rst = 0; tmr_ld = 0;
  endtask

  initial begin
    int ovf_cnt;
    int seq [5];
    bit found;
    sys_rst = 1; sys_clk_en = 1; tmr_on = 1;
    tmr_start = 0; tmr_stop = 0; tmr_rst = 0; tmr_ld = 0;
    tmr_ld_val = '0; tmr_period = '0; tmr_dir = 0; tmr_one_shot = 0;
    tmr_psc = '0; ch_match_val = '0; ch_match_en = '0; ovf_en = 1;
    model_reset();
    #12;
    check("rst_value",   32'(tmr_value),   32'd0);
    check("rst_running", 32'(tmr_running), 32'd0);
    check("rst_match",   32'(match_event), 32'd0);
    check("rst_ovf",     32'(ovf_event),   32'd0);
    sys_rst = 0;
    @(posedge sys_clk); #1;

    // psc=0, period=4, up, auto-reload
    tmr_period = 8'd4; tmr_psc = '0; tmr_start = 1;
    cyc();
    check("t1_run", 32'(tmr_running), 32'd1);
    check("t1_v0",  32'(tmr_value),   32'd0);
    seq = '{1, 2, 3, 4, 0};
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("t1_seq", 32'(tmr_value), 32'(seq[k]));
    end
    check("t1_ovf", 32'(ovf_event),   32'd1);
    check("t1_keep", 32'(tmr_running), 32'd1);

    // psc=2, period=2: one ovf per 9 cycles
    tmr_psc = 4'd2; tmr_period = 8'd2; tmr_rst = 1;
    cyc();
    ovf_cnt = 0;
    for (int k = 0; k < 18; k++) begin
      cyc();
      if (ovf_event) ovf_cnt++;
    end
    check("t2_ovf_cnt", 32'(ovf_cnt), 32'd2);

    // down, one-shot, load 3
    tmr_psc = '0; tmr_dir = 1; tmr_one_shot = 1; tmr_period = 8'd6;
    tmr_ld = 1; tmr_ld_val = 8'd3;
    cyc();
    ovf_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (ovf_event) ovf_cnt++;
    end
    check("t3_ovf_cnt", 32'(ovf_cnt),    32'd1);
    check("t3_run",     32'(tmr_running), 32'd0);
    check("t3_value",   32'(tmr_value),   32'd6);

    // two channels matching the same value
    tmr_dir = 0; tmr_one_shot = 0; tmr_period = 8'd5;
    ch_match_val = {8'd2, 8'd2}; ch_match_en = 2'b11;
    tmr_rst = 1; tmr_start = 1;
    cyc();
    cyc();
    cyc();
    check("t4_val",   32'(tmr_value),   32'd2);
    check("t4_match", 32'(match_event), 32'd3);

    // tmr_rst on the tick that would reach the match value
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (tmr_value == 8'd1) found = 1;
      else cyc();
    end
    check("t5_find", 32'(found), 32'd1);
    tmr_rst = 1;
    cyc();
    check("t5_val",   32'(tmr_value),   32'd0);
    check("t5_match", 32'(match_event), 32'd0);
    check("t5_ovf",   32'(ovf_event),   32'd0);

    // stop and start together
    tmr_stop = 1; tmr_start = 1;
    cyc();
    check("t6_run", 32'(tmr_running), 32'd0);

    // asynchronous reset mid-count
    tmr_start = 1;
    cyc(); cyc(); cyc();
    #2 sys_rst = 1;
    #1;
    model_reset();
    check("t7_value", 32'(tmr_value),   32'd0);
    check("t7_run",   32'(tmr_running), 32'd0);
    check("t7_ev",    32'({match_event, ovf_event}), 32'd0);
    @(negedge sys_clk);
    sys_rst = 0;
    @(posedge sys_clk); #1;

    // randomised phase
    for (int k = 0; k < 3000; k++) begin
      if (k % 60 == 0) begin
        tmr_period   = ($urandom % 4 == 0) ? N'($urandom) : N'($urandom % 12);
        tmr_psc      = PSC_W'($urandom % 4);
        tmr_dir      = 1'($urandom);
        tmr_one_shot = ($urandom % 4 == 0);
        ch_match_val = {N'($urandom % 12), N'($urandom % 12)};
        ch_match_en  = NUM_CH'($urandom);
        ovf_en       = ($urandom % 5 != 0);
      end
      sys_clk_en = ($urandom % 8 != 0);
      tmr_on     = ($urandom % 10 != 0);
      tmr_start  = ($urandom % 6 == 0);
      tmr_stop   = ($urandom % 20 == 0);
      tmr_rst    = ($urandom % 40 == 0);
      tmr_ld     = ($urandom % 30 == 0);
      tmr_ld_val = ($urandom % 3 == 0) ? N'($urandom) : N'($urandom % 12);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
